// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg
// Purpose  : Shared types and helpers for the sequential shift-and-add
//            multiplier (controller state encoding, step counter sizing).
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

  // Controller states. The encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The step counter needs to hold values up to WIDTH-1 without wrapping.
  // One extra bit beyond $clog2 keeps headroom for any WIDTH.
  function automatic int step_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_fsm.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_fsm
// Purpose  : Control sequencer for the shift-and-add multiplier.
// Ports    : clock      - system clock
//            reset_L    - asynchronous active-low reset
//            start      - operation request (honoured only in IDLE)
//            last_step  - datapath is on its final iteration
//            ready      - high in IDLE
//            done       - high for the single DONE cycle
//            load       - load operands / clear accumulator and step
//            shift_en   - perform one add-and-shift iteration
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_fsm
  import seq_mult_pkg::*;
(
  input  logic clock,
  input  logic reset_L,
  input  logic start,
  input  logic last_step,
  output logic ready,
  output logic done,
  output logic load,
  output logic shift_en
);

  mult_state_t r_state;
  mult_state_t w_next_state;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ready and done decode the state register only, so they have no
  // combinational path from start. load does depend on start, but it
  // only feeds internal register enables.
  always_comb begin
    w_next_state = IDLE;
    ready        = 1'b0;
    done         = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load         = 1'b1;
          w_next_state = CALC;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        shift_en     = 1'b1;
        w_next_state = last_step ? DONE : CALC;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule : seq_mult_fsm
`default_nettype wire

// File: rtl/seq_mult_lib.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_adder / seq_mult_counter
// Purpose  : Datapath building blocks used by seq_multiplier.
//   seq_mult_adder   : WIDTH-bit ripple adder with carry-in and carry-out.
//     i_a, i_b [WIDTH-1:0] operands, i_cin carry-in,
//     o_sum [WIDTH-1:0] sum, o_cout carry-out.
//   seq_mult_counter : up-counter with synchronous clear and enable.
//     clock, reset_L (async, active-low), i_clear, i_en,
//     o_count [WIDTH-1:0].
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Extend every term to WIDTH+1 bits so the carry-out is never lost.
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule : seq_mult_adder

module seq_mult_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority so a new operation always starts from zero.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : seq_mult_counter
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Unsigned shift-and-add multiplier producing a 2*WIDTH-bit
//            product over WIDTH iterations using one adder.
// Ports    : clock   - system clock
//            reset_L - asynchronous active-low reset
//            start   - request, accepted on a rising edge while ready=1
//            A, B    - multiplicand / multiplier, sampled when accepted
//            ready   - high while idle
//            done    - one-cycle pulse when P becomes valid
//            P       - product, held until overwritten by the next result
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int STEP_W = step_width(WIDTH);
  localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;

  logic [STEP_W-1:0]  w_step;
  logic               w_last_step;
  logic               w_load;
  logic               w_shift_en;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_next_acc;
  logic [WIDTH-1:0]   w_next_mplr;

  seq_mult_fsm u_fsm (
    .clock     (clock),
    .reset_L   (reset_L),
    .start     (start),
    .last_step (w_last_step),
    .ready     (ready),
    .done      (done),
    .load      (w_load),
    .shift_en  (w_shift_en)
  );

  seq_mult_counter #(
    .WIDTH (STEP_W)
  ) u_step (
    .clock   (clock),
    .reset_L (reset_L),
    .i_clear (w_load),
    .i_en    (w_shift_en),
    .o_count (w_step)
  );

  assign w_last_step = (w_step == C_LAST_STEP);

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend = r_mplr[0] ? r_mcand : '0;

  seq_mult_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  // {carry, sum, mplr} shifted right by one: the carry becomes the new
  // accumulator MSB and the sum LSB moves into the multiplier register,
  // whose consumed LSB falls off the end.
  assign w_next_acc  = {w_carry, w_sum[WIDTH-1:1]};
  assign w_next_mplr = {w_sum[0], r_mplr[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
    end else if (w_load) begin
      r_acc   <= '0;
      r_mplr  <= B;
      r_mcand <= A;
    end else if (w_shift_en) begin
      r_acc   <= w_next_acc;
      r_mplr  <= w_next_mplr;
    end
  end

  // The product is captured on the same edge as the final iteration so
  // that it is valid during the DONE cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_p <= '0;
    end else if (w_shift_en && w_last_step) begin
      r_p <= {w_next_acc, w_next_mplr};
    end
  end

  assign P = r_p;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Self-checking bench for seq_multiplier (WIDTH=4). A reference
//            model records each accepted request with its product and the
//            edge at which done must appear; a monitor compares outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clock;
  logic          reset_L;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          ready;
  logic          done;
  logic [PW-1:0] P;

  seq_multiplier #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .start   (start),
    .A       (A),
    .B       (B),
    .ready   (ready),
    .done    (done),
    .P       (P)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] prod;
    int            edge_n;
  } exp_t;

  exp_t          q[$];
  int            cyc       = 0;
  int            next_free = 0;
  logic [PW-1:0] model_p   = '0;
  int            cmp_cnt   = 0;
  int            err_cnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a request is taken whenever start is high and the
  // previous operation (WIDTH+2 cycles long) has finished.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset_L && start && cyc >= next_free) begin
      q.push_back('{prod: PW'(A) * PW'(B), edge_n: cyc + W});
      next_free = cyc + W + 2;
    end
  end

  // Monitor: compare outputs against the model every cycle.
  always @(negedge clock) begin
    logic exp_done;
    exp_t e;
    if (reset_L) begin
      while (q.size() > 0 && q[0].edge_n < cyc) begin
        e = q.pop_front();
        err_cnt++;
        $display("FAIL missed_done: got no done expected product %0d by edge %0d", e.prod, e.edge_n);
      end
      exp_done = (q.size() > 0) && (q[0].edge_n == cyc);
      if (exp_done) begin
        e = q.pop_front();
        model_p = e.prod;
      end
      chk("done", 64'(done), 64'(exp_done));
      chk("ready", 64'(ready), 64'(cyc + 1 >= next_free));
      chk("P", 64'(P), 64'(model_p));
    end
  end

  // Wait (bounded) until the model says the DUT is idle at this negedge.
  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (cyc + 1 < next_free && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      err_cnt++;
      $display("FAIL wait_idle: got busy expected idle within 50 cycles");
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_P"}, 64'(P), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_L = 1'b0;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    #2 reset_L = 1'b1;

    // Directed products.
    do_op(4'd13, 4'd11);
    do_op(4'd15, 4'd15);
    do_op(4'd0, 4'd9);
    do_op(4'd9, 4'd0);

    // Start held high; operands change right after the first accept.
    wait_idle();
    A = 4'd3;
    B = 4'd5;
    start = 1'b1;
    @(negedge clock);
    A = 4'd6;
    B = 4'd7;
    repeat (W + 2) @(negedge clock);
    start = 1'b0;

    // Reset in the middle of a calculation.
    do_op(4'd13, 4'd11);
    @(negedge clock);
    #2 reset_L = 1'b0;
    q.delete();
    next_free = 0;
    model_p   = '0;
    #1 check_reset_values("midreset");
    @(negedge clock);
    #2 reset_L = 1'b1;

    // Fresh operation, then idle hold with toggling operands.
    do_op(4'd13, 4'd11);
    wait_idle();
    repeat (12) begin
      A = W'($urandom);
      B = W'($urandom);
      @(negedge clock);
    end

    // Randomised traffic with varying start pulse lengths.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      A = W'($urandom);
      B = W'($urandom);
      start = 1'b1;
      repeat ($urandom_range(1, 8)) begin
        @(negedge clock);
        A = W'($urandom);
        B = W'($urandom);
      end
      start = 1'b0;
    end

    // Drain outstanding results.
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    cmp_cnt++;
    if (q.size() > 0) begin
      err_cnt++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_seq_multiplier
`default_nettype wire
